alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  - 32-bit integer ALU for the single-cycle RISC-V datapath (execute stage).
//  - Performs add, sub, and, or, xor, slt and sltu, selected by ALUControl.
//  - Produces Result plus Z/N/V/C condition flags.
//  - Result and flags are registered: 1-cycle latency, one clock, synchronous reset.
// PARAMETERS
//  - WIDTH  32  datapath width of A, B and Result; all rules below scale with WIDTH.
// PORTS
//  - clk         in   1      clock; all state updates on rising edge
//  - rst         in   1      reset; synchronous, active-high
//  - A           in   WIDTH  operand A (rs1)
//  - B           in   WIDTH  operand B (rs2 or immediate)
//  - ALUControl  in   3      operation select
//  - Result      out  WIDTH  registered operation result
//  - Z           out  1      registered zero flag
//  - N           out  1      registered negative flag
//  - V           out  1      registered signed-overflow flag
//  - C           out  1      registered carry flag
// BEHAVIOUR
//  - Reset: rising clk with rst=1 sets Result=0, Z=1, N=0, V=0, C=0.
//    - rst has priority over the operands presented in the same cycle.
//    - Reset mid-operation discards the pending result.
//  - Latency: inputs sampled on rising edge N; Result and flags valid after edge N.
//    - Holds until the next edge. New operation accepted every cycle; no handshake.
//  - ALUControl encoding (two's complement, all arithmetic modulo 2^WIDTH):
//    - 000  ADD   A + B
//    - 001  SUB   A + ~B + 1
//    - 010  AND   A & B
//    - 011  OR    A | B
//    - 100  XOR   A ^ B
//    - 101  SLT   {0..0, (A <s B)}; computed as N^V of A-B, so no overflow error
//    - 110  SLTU  {0..0, (A <u B)}; computed as ~carry of A-B
//    - 111  reserved; Result=0, flags follow the rules below (Z=1)
//  - Single shared adder: sum = A + (sub ? ~B : B) + sub, with sub=1 for 001/101/110.
//  - Z = (Result == 0), all ops.
//  - N = Result[WIDTH-1], all ops.
//  - C (ADD/SUB only, else 0):
//    - carry-out of the adder at bit WIDTH.
//    - For SUB, C=1 means no borrow (A >=u B).
//  - V (ADD/SUB only, else 0):
//    - operands share sign and the sum sign differs.
//    - For SUB, evaluated on A and ~B: V = (A[msb]^B[msb]) & (A[msb]^sum[msb]).
//  - SLT/SLTU report V=0, C=0; Z/N derived from their 0/1 Result.
//  - No X propagation: every ALUControl value yields a defined Result.
// TESTING
//  - ADD 10+20 -> 30, Z=0 N=0 V=0 C=0; then A=0 B=0 ADD -> 0, Z=1.
//  - SUB 30-10 -> 20, C=1 V=0; SUB 10-20 -> 0xFFFFFFF6, N=1 C=0.
//  - AND/OR FFFF0000,0000FFFF -> AND 0 (Z=1); OR FFFFFFFF (N=1).
//  - SLT 10,20 -> 1; SLT 20,10 -> 0; SLT 0x80000000,1 -> 1; SLTU same -> 0.
//  - ADD 7FFFFFFF+1 -> 80000000, N=1 V=1 C=0.
//  - ADD FFFFFFFF+1 -> 0, Z=1 C=1 V=0; ADD -10+5 -> FFFFFFFB, N=1.
//  - Latency/reset: result appears 1 edge after inputs.
//    - rst=1 with live operands -> Result=0, Z=1, others 0 next edge.

Source files
------------

// File: rtl/alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu : 32-bit RISC-V execute-stage ALU, registered result and Z/N/V/C |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             C
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;

  logic             w_sub;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_ovf;
  logic             w_lt_s;
  logic             w_lt_u;
  logic [WIDTH-1:0] w_result;
  logic             w_arith;

  // One shared adder serves ADD, SUB and both compares.
  assign w_sub  = (ALUControl == OP_SUB) || (ALUControl == OP_SLT) ||
                  (ALUControl == OP_SLTU);
  assign w_b_op = w_sub ? ~B : B;
  assign {w_carry, w_sum} = {1'b0, A} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};

  assign w_ovf  = ~(A[WIDTH-1] ^ w_b_op[WIDTH-1]) & (A[WIDTH-1] ^ w_sum[WIDTH-1]);
  assign w_lt_s = w_sum[WIDTH-1] ^ w_ovf;
  assign w_lt_u = ~w_carry;
  assign w_arith = (ALUControl == OP_ADD) || (ALUControl == OP_SUB);

  always_comb begin
    w_result = '0;
    case (ALUControl)
      OP_ADD, OP_SUB: w_result = w_sum;
      OP_AND:         w_result = A & B;
      OP_OR:          w_result = A | B;
      OP_XOR:         w_result = A ^ B;
      OP_SLT:         w_result = {{(WIDTH-1){1'b0}}, w_lt_s};
      OP_SLTU:        w_result = {{(WIDTH-1){1'b0}}, w_lt_u};
      default:        w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Result <= '0;
      Z      <= 1'b1;
      N      <= 1'b0;
      V      <= 1'b0;
      C      <= 1'b0;
    end else begin
      Result <= w_result;
      Z      <= (w_result == '0);
      N      <= w_result[WIDTH-1];
      V      <= w_arith & w_ovf;
      C      <= w_arith & w_carry;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu : directed vector bench for alu                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       ctrl;
  logic [WIDTH-1:0] result;
  logic             z, n, v, c;

  int tests_run;
  int tests_failed;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  znvc;
  } vec_t;

  vec_t vecs[$];

  alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .ALUControl(ctrl),
    .Result(result), .Z(z), .N(n), .V(v), .C(c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] exp_res,
                       input logic [3:0] exp_znvc);
    tests_run++;
    if (result !== exp_res || {z, n, v, c} !== exp_znvc) begin
      tests_failed++;
      $display("FAIL %s: got Result=%08h ZNVC=%04b, expected Result=%08h ZNVC=%04b",
               name, result, {z, n, v, c}, exp_res, exp_znvc);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] op,
                       input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    rst  = r;
    ctrl = op;
    a    = va;
    b    = vb;
  endtask

  function automatic vec_t mk(input string nm, input logic [2:0] op,
                              input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] r, input logic [3:0] f);
    vec_t t;
    t.name = nm; t.op = op; t.a = va; t.b = vb; t.res = r; t.znvc = f;
    return t;
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1; ctrl = 3'b000; a = '0; b = '0;

    //                 name          op      A             B             Result        ZNVC
    vecs.push_back(mk("add_10_20",   3'b000, 32'd10,       32'd20,       32'd30,       4'b0000));
    vecs.push_back(mk("add_0_0",     3'b000, 32'd0,        32'd0,        32'd0,        4'b1000));
    vecs.push_back(mk("sub_30_10",   3'b001, 32'd30,       32'd10,       32'd20,       4'b0001));
    vecs.push_back(mk("sub_10_20",   3'b001, 32'd10,       32'd20,       32'hFFFFFFF6, 4'b0100));
    vecs.push_back(mk("and_masks",   3'b010, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 4'b1000));
    vecs.push_back(mk("or_masks",    3'b011, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF, 4'b0100));
    vecs.push_back(mk("xor_pat",     3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000));
    vecs.push_back(mk("slt_10_20",   3'b101, 32'd10,       32'd20,       32'd1,        4'b0000));
    vecs.push_back(mk("slt_20_10",   3'b101, 32'd20,       32'd10,       32'd0,        4'b1000));
    vecs.push_back(mk("slt_min_1",   3'b101, 32'h80000000, 32'd1,        32'd1,        4'b0000));
    vecs.push_back(mk("sltu_min_1",  3'b110, 32'h80000000, 32'd1,        32'd0,        4'b1000));
    vecs.push_back(mk("slt_max_min", 3'b101, 32'h7FFFFFFF, 32'h80000000, 32'd0,        4'b1000));
    vecs.push_back(mk("sltu_1_2",    3'b110, 32'd1,        32'd2,        32'd1,        4'b0000));
    vecs.push_back(mk("add_ovf",     3'b000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b0110));
    vecs.push_back(mk("add_wrap",    3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1001));
    vecs.push_back(mk("add_neg",     3'b000, 32'hFFFFFFF6, 32'd5,        32'hFFFFFFFB, 4'b0100));
    vecs.push_back(mk("sub_ovf",     3'b001, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b0011));
    vecs.push_back(mk("sub_equal",   3'b001, 32'd5,        32'd5,        32'd0,        4'b1001));
    vecs.push_back(mk("reserved",    3'b111, 32'd5,        32'd5,        32'd0,        4'b1000));

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_state", 32'd0, 4'b1000);

    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      check(vecs[i].name, vecs[i].res, vecs[i].znvc);
    end

    // Latency: output changes only on the edge after the inputs change
    drive(1'b0, 3'b000, 32'd1, 32'd2);
    @(posedge clk); #1;
    check("lat_first", 32'd3, 4'b0000);
    drive(1'b0, 3'b000, 32'd100, 32'd200);
    #1;
    check("lat_hold", 32'd3, 4'b0000);
    @(posedge clk); #1;
    check("lat_next", 32'd300, 4'b0000);

    // Reset with live operands wins and discards the pending result
    drive(1'b1, 3'b000, 32'h7FFFFFFF, 32'd1);
    @(posedge clk); #1;
    check("rst_priority", 32'd0, 4'b1000);
    drive(1'b0, 3'b001, 32'd10, 32'd20);
    @(posedge clk); #1;
    check("post_rst_sub", 32'hFFFFFFF6, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
